// File: rtl/pll_reconf_ctrl.sv
// Run-time PLL reconfiguration sequencer: gates the system clock, applies a new PLL code,
// waits for a filtered relock with timeout, and falls back to the bypass code on failure.
module pll_reconf_ctrl #(
    parameter int LOCK_FILT = 16,
    parameter int TIMEOUT   = 4096,
    parameter int GATE_DLY  = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_valid_i,
    input  logic [2:0] req_cfg_i,
    output logic       req_ready_o,
    input  logic       err_clr_i,
    input  logic       pll_lock_i,
    output logic [2:0] pll_cfg_o,
    output logic [2:0] cur_cfg_o,
    output logic       clk_gate_en_o,
    output logic       periph_rst_n_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [2:0] {BOOT, RUN, GATE, APPLY, WAIT_LOCK, UNGATE, HALT} state_t;

    state_t      state, next_state;
    logic        sync1, lock_s;
    logic [7:0]  filt_cnt;
    logic [7:0]  dly_cnt;
    logic [15:0] to_cnt;
    logic [2:0]  new_cfg;
    logic        fallback;
    logic        quiet;
    logic        lock_ok, timeout, dly_done;
    logic        enter_wait, accept_new, accept_same, lock_loss;
    logic        first_to, relocked, finish, halt_go;

    assign lock_ok     = (filt_cnt == 8'(LOCK_FILT));
    assign timeout     = (to_cnt == 16'(TIMEOUT - 1));
    assign dly_done    = (dly_cnt == 8'(GATE_DLY - 1));
    assign busy_o      = (state != RUN);
    // Ready is withheld while lock is lost so a held request waits for the return to RUN.
    assign req_ready_o = (state == RUN) && lock_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= BOOT;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        enter_wait  = 1'b0;
        accept_new  = 1'b0;
        accept_same = 1'b0;
        lock_loss   = 1'b0;
        first_to    = 1'b0;
        relocked    = 1'b0;
        finish      = 1'b0;
        halt_go     = 1'b0;
        case (state)
            BOOT, WAIT_LOCK: begin
                if (lock_ok) begin
                    relocked   = 1'b1;
                    next_state = UNGATE;
                end else if (timeout) begin
                    if (fallback) begin
                        halt_go    = 1'b1;
                        next_state = HALT;
                    end else begin
                        first_to   = 1'b1;
                        enter_wait = 1'b1;
                        next_state = WAIT_LOCK;
                    end
                end
            end
            RUN: begin
                if (!lock_s) begin
                    lock_loss  = 1'b1;
                    enter_wait = 1'b1;
                    next_state = WAIT_LOCK;
                end else if (req_valid_i) begin
                    if (req_cfg_i == cur_cfg_o) begin
                        accept_same = 1'b1;
                    end else begin
                        accept_new = 1'b1;
                        next_state = GATE;
                    end
                end
            end
            GATE: begin
                if (dly_done) next_state = APPLY;
            end
            APPLY: begin
                enter_wait = 1'b1;
                next_state = WAIT_LOCK;
            end
            UNGATE: begin
                if (dly_done) begin
                    finish     = 1'b1;
                    next_state = RUN;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1          <= 1'b0;
            lock_s         <= 1'b0;
            filt_cnt       <= '0;
            to_cnt         <= '0;
            dly_cnt        <= '0;
            new_cfg        <= 3'b000;
            fallback       <= 1'b0;
            quiet          <= 1'b1;
            pll_cfg_o      <= 3'b000;
            cur_cfg_o      <= 3'b000;
            clk_gate_en_o  <= 1'b0;
            periph_rst_n_o <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            sync1  <= pll_lock_i;
            lock_s <= sync1;

            if (enter_wait || !lock_s) filt_cnt <= '0;
            else if (!lock_ok)         filt_cnt <= filt_cnt + 8'd1;

            if (enter_wait)                                to_cnt <= '0;
            else if (state == BOOT || state == WAIT_LOCK) to_cnt <= to_cnt + 16'd1;

            if ((state == GATE || state == UNGATE) && !dly_done) dly_cnt <= dly_cnt + 8'd1;
            else                                                 dly_cnt <= '0;

            if (accept_new)     new_cfg <= req_cfg_i;
            else if (lock_loss) new_cfg <= cur_cfg_o;

            if (state == APPLY) pll_cfg_o <= new_cfg;
            else if (first_to)  pll_cfg_o <= 3'b000;

            if (relocked) cur_cfg_o <= pll_cfg_o;

            if (first_to)    fallback <= 1'b1;
            else if (finish) fallback <= 1'b0;

            // Boot and lock-loss recoveries complete silently; only software requests report done.
            if (lock_loss)   quiet <= 1'b1;
            else if (finish) quiet <= 1'b0;

            if (lock_loss || accept_new || halt_go) clk_gate_en_o <= 1'b0;
            else if (finish)                        clk_gate_en_o <= 1'b1;

            if (halt_go)     periph_rst_n_o <= 1'b0;
            else if (finish) periph_rst_n_o <= 1'b1;

            done_o <= accept_same || (finish && !quiet && !fallback);

            if (halt_go || first_to || state == HALT) err_o <= 1'b1;
            else if (err_clr_i)                        err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// Self-checking bench for pll_reconf_ctrl: a behavioural PLL/timing model predicts the
// cycle of every gate, apply, relock, done and error event from the block's timing rules.
module tb_pll_reconf_ctrl;

    localparam int LOCK_FILT = 16;
    localparam int TIMEOUT   = 4096;
    localparam int GATE_DLY  = 8;
    // Cycles from the lock input rising to the ungate/done edge.
    localparam int RELOCK_LAT = 2 + LOCK_FILT + GATE_DLY + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_cfg = 3'b000;
    logic       req_ready;
    logic       err_clr = 1'b0;
    logic       pll_lock = 1'b0;
    logic [2:0] pll_cfg, cur_cfg;
    logic       gate_en, periph_rst_n, busy, done, err;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [2:0] cur_model = 3'b000;

    always #5 clk = ~clk;

    pll_reconf_ctrl #(.LOCK_FILT(LOCK_FILT), .TIMEOUT(TIMEOUT), .GATE_DLY(GATE_DLY)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_cfg_i(req_cfg),
        .req_ready_o(req_ready), .err_clr_i(err_clr), .pll_lock_i(pll_lock),
        .pll_cfg_o(pll_cfg), .cur_cfg_o(cur_cfg), .clk_gate_en_o(gate_en),
        .periph_rst_n_o(periph_rst_n), .busy_o(busy), .done_o(done), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pick_code(input logic [2:0] avoid);
        logic [2:0] c;
        c = 3'($urandom_range(7, 2));
        while (c == avoid) c = 3'($urandom_range(7, 2));
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        pll_lock = 1'b1;
        repeat (3) tick();
        n_checks++; if (pll_cfg !== 3'b000) $display("[TB] FAIL rst_pll_cfg: got %0h expected 0", pll_cfg); else n_pass++;
        n_checks++; if (cur_cfg !== 3'b000) $display("[TB] FAIL rst_cur_cfg: got %0h expected 0", cur_cfg); else n_pass++;
        n_checks++; if (gate_en !== 1'b0) $display("[TB] FAIL rst_gate: got %0b expected 0", gate_en); else n_pass++;
        n_checks++; if (periph_rst_n !== 1'b0) $display("[TB] FAIL rst_periph: got %0b expected 0", periph_rst_n); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("[TB] FAIL rst_ready: got %0b expected 0", req_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL rst_busy: got %0b expected 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL rst_done: got %0b expected 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL rst_err: got %0b expected 0", err); else n_pass++;
        rst_n = 1'b1;
        // Lock is already high at release, so the whole boot is one relock latency.
        for (int k = 1; k <= RELOCK_LAT + 2; k++) begin
            tick();
            n_checks++; if (gate_en !== 1'(k >= RELOCK_LAT)) $display("[TB] FAIL boot_gate k=%0d: got %0b expected %0b", k, gate_en, k >= RELOCK_LAT); else n_pass++;
            n_checks++; if (periph_rst_n !== 1'(k >= RELOCK_LAT)) $display("[TB] FAIL boot_periph k=%0d: got %0b expected %0b", k, periph_rst_n, k >= RELOCK_LAT); else n_pass++;
            n_checks++; if (done !== 1'b0) $display("[TB] FAIL boot_done k=%0d: got %0b expected 0", k, done); else n_pass++;
        end
        n_checks++; if (cur_cfg !== 3'b000) $display("[TB] FAIL boot_cur_cfg: got %0h expected 0", cur_cfg); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL boot_ready: got %0b expected 1", req_ready); else n_pass++;
    endtask

    task automatic do_reconfig(input logic [2:0] code, input int n_drop);
        int t_apply, t_relock, t_done;
        logic [2:0] old;
        old      = cur_model;
        t_apply  = 1 + GATE_DLY + 1;
        t_relock = t_apply + n_drop;
        t_done   = t_relock + RELOCK_LAT;
        n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reconf_ready: got %0b expected 1", req_ready); else n_pass++;
        req_valid = 1'b1;
        req_cfg   = code;
        for (int k = 1; k <= t_done; k++) begin
            tick();
            if (k == 1) req_valid = 1'b0;
            // PLL model: loses lock as soon as the new code appears, regains it n_drop cycles later.
            if (k == t_apply) pll_lock = 1'b0;
            if (k == t_relock) pll_lock = 1'b1;
            n_checks++; if (gate_en !== 1'(k == t_done)) $display("[TB] FAIL reconf_gate k=%0d: got %0b expected %0b", k, gate_en, k == t_done); else n_pass++;
            n_checks++; if (pll_cfg !== ((k >= t_apply) ? code : old)) $display("[TB] FAIL reconf_pll_cfg k=%0d: got %0h expected %0h", k, pll_cfg, (k >= t_apply) ? code : old); else n_pass++;
            n_checks++; if (done !== 1'(k == t_done)) $display("[TB] FAIL reconf_done k=%0d: got %0b expected %0b", k, done, k == t_done); else n_pass++;
        end
        cur_model = code;
        n_checks++; if (cur_cfg !== cur_model) $display("[TB] FAIL reconf_cur_cfg: got %0h expected %0h", cur_cfg, cur_model); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL reconf_err: got %0b expected 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reconf_busy: got %0b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reconf_done_pulse: got %0b expected 0", done); else n_pass++;
    endtask

    task automatic test_reconfig(input int n);
        for (int i = 0; i < n; i++) do_reconfig(pick_code(cur_model), int'($urandom_range(60, 20)));
    endtask

    task automatic test_same_code();
        n_checks++; if (req_ready !== 1'b1) $display("[TB] FAIL same_ready: got %0b expected 1", req_ready); else n_pass++;
        req_valid = 1'b1;
        req_cfg   = cur_model;
        for (int k = 1; k <= 5; k++) begin
            tick();
            req_valid = 1'b0;
            n_checks++; if (done !== 1'(k == 1)) $display("[TB] FAIL same_done k=%0d: got %0b expected %0b", k, done, k == 1); else n_pass++;
            n_checks++; if (gate_en !== 1'b1) $display("[TB] FAIL same_gate k=%0d: got %0b expected 1", k, gate_en); else n_pass++;
        end
        n_checks++; if (cur_cfg !== cur_model) $display("[TB] FAIL same_cur_cfg: got %0h expected %0h", cur_cfg, cur_model); else n_pass++;
    endtask

    task automatic test_lock_loss();
        logic [2:0] code;
        int t_rise;
        code   = pick_code(cur_model);
        t_rise = 3 + RELOCK_LAT;
        pll_lock = 1'b0;
        for (int k = 1; k <= t_rise; k++) begin
            tick();
            // Request raised once the loss is visible; it must wait for the return to RUN.
            if (k == 2) begin
                req_valid = 1'b1;
                req_cfg   = code;
            end
            if (k == 3) pll_lock = 1'b1;
            n_checks++; if (gate_en !== 1'(k < 3 || k >= t_rise)) $display("[TB] FAIL loss_gate k=%0d: got %0b expected %0b", k, gate_en, k < 3 || k >= t_rise); else n_pass++;
            n_checks++; if (pll_cfg !== cur_model) $display("[TB] FAIL loss_pll_cfg k=%0d: got %0h expected %0h", k, pll_cfg, cur_model); else n_pass++;
            n_checks++; if (done !== 1'b0) $display("[TB] FAIL loss_done k=%0d: got %0b expected 0", k, done); else n_pass++;
            if (k >= 2 && k < t_rise) begin
                n_checks++; if (req_ready !== 1'b0) $display("[TB] FAIL loss_ready k=%0d: got %0b expected 0", k, req_ready); else n_pass++;
            end
        end
        do_reconfig(code, int'($urandom_range(60, 20)));
    endtask

    task automatic test_timeout_fallback();
        logic [2:0] code;
        int t_apply, t_to, t_rise;
        code    = (cur_model == 3'b111) ? 3'b110 : 3'b111;
        t_apply = 1 + GATE_DLY + 1;
        t_to    = t_apply + TIMEOUT;
        t_rise  = t_to + int'($urandom_range(40, 5)) + RELOCK_LAT;
        req_valid = 1'b1;
        req_cfg   = code;
        for (int k = 1; k <= t_rise; k++) begin
            tick();
            if (k == 1) req_valid = 1'b0;
            if (k == t_apply) pll_lock = 1'b0;
            if (k == t_rise - RELOCK_LAT) pll_lock = 1'b1;
            if (k == t_to - 1) begin
                n_checks++; if (err !== 1'b0) $display("[TB] FAIL to_err_early: got %0b expected 0", err); else n_pass++;
                n_checks++; if (pll_cfg !== code) $display("[TB] FAIL to_pll_cfg_early: got %0h expected %0h", pll_cfg, code); else n_pass++;
            end
            if (k == t_to) begin
                n_checks++; if (err !== 1'b1) $display("[TB] FAIL to_err: got %0b expected 1", err); else n_pass++;
                n_checks++; if (pll_cfg !== 3'b000) $display("[TB] FAIL to_pll_cfg: got %0h expected 0", pll_cfg); else n_pass++;
            end
            if (k >= t_to) begin
                n_checks++; if (gate_en !== 1'(k == t_rise)) $display("[TB] FAIL fb_gate k=%0d: got %0b expected %0b", k, gate_en, k == t_rise); else n_pass++;
                n_checks++; if (done !== 1'b0) $display("[TB] FAIL fb_done k=%0d: got %0b expected 0", k, done); else n_pass++;
            end
        end
        cur_model = 3'b000;
        n_checks++; if (cur_cfg !== 3'b000) $display("[TB] FAIL fb_cur_cfg: got %0h expected 0", cur_cfg); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("[TB] FAIL fb_err_sticky: got %0b expected 1", err); else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL fb_err_clr: got %0b expected 0", err); else n_pass++;
        tick();
    endtask

    task automatic test_double_failure();
        logic [2:0] code;
        int t_apply, t_to1, t_to2;
        code    = pick_code(cur_model);
        t_apply = 1 + GATE_DLY + 1;
        t_to1   = t_apply + TIMEOUT;
        t_to2   = t_to1 + TIMEOUT;
        req_valid = 1'b1;
        req_cfg   = code;
        for (int k = 1; k <= t_to2; k++) begin
            tick();
            if (k == 1) req_valid = 1'b0;
            if (k == t_apply) pll_lock = 1'b0;
            if (k == t_to1 - 1) begin
                n_checks++; if (err !== 1'b0) $display("[TB] FAIL df_err_early: got %0b expected 0", err); else n_pass++;
                err_clr = 1'b1;
            end
            if (k == t_to1) begin
                err_clr = 1'b0;
                n_checks++; if (err !== 1'b1) $display("[TB] FAIL df_err_set_wins: got %0b expected 1", err); else n_pass++;
                n_checks++; if (pll_cfg !== 3'b000) $display("[TB] FAIL df_pll_cfg: got %0h expected 0", pll_cfg); else n_pass++;
            end
            if (k == t_to2 - 1) begin
                n_checks++; if (periph_rst_n !== 1'b1) $display("[TB] FAIL df_periph_early: got %0b expected 1", periph_rst_n); else n_pass++;
            end
        end
        n_checks++; if (periph_rst_n !== 1'b0) $display("[TB] FAIL halt_periph: got %0b expected 0", periph_rst_n); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("[TB] FAIL halt_ready: got %0b expected 0", req_ready); else n_pass++;
        n_checks++; if (gate_en !== 1'b0) $display("[TB] FAIL halt_gate: got %0b expected 0", gate_en); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("[TB] FAIL halt_err: got %0b expected 1", err); else n_pass++;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        n_checks++; if (err !== 1'b1) $display("[TB] FAIL halt_err_clr: got %0b expected 1", err); else n_pass++;
        n_checks++; if (cur_cfg !== cur_model) $display("[TB] FAIL halt_cur_cfg: got %0h expected %0h", cur_cfg, cur_model); else n_pass++;
        // Reset asserted between clock edges must take effect without waiting for one.
        #2 rst_n = 1'b0;
        #1;
        cur_model = 3'b000;
        n_checks++; if (pll_cfg !== 3'b000) $display("[TB] FAIL arst_pll_cfg: got %0h expected 0", pll_cfg); else n_pass++;
        n_checks++; if (cur_cfg !== 3'b000) $display("[TB] FAIL arst_cur_cfg: got %0h expected 0", cur_cfg); else n_pass++;
        n_checks++; if (gate_en !== 1'b0) $display("[TB] FAIL arst_gate: got %0b expected 0", gate_en); else n_pass++;
        n_checks++; if (periph_rst_n !== 1'b0) $display("[TB] FAIL arst_periph: got %0b expected 0", periph_rst_n); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("[TB] FAIL arst_ready: got %0b expected 0", req_ready); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("[TB] FAIL arst_busy: got %0b expected 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL arst_done: got %0b expected 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("[TB] FAIL arst_err: got %0b expected 0", err); else n_pass++;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_reconfig(3);
        test_same_code();
        test_lock_loss();
        test_timeout_fallback();
        test_reconfig(1);
        test_double_failure();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
